// File: rtl/serial_tx_framer.sv
// Parallel-to-serial TX line framer: start bit, LSB-first payload, one stop bit,
// each bit held CLKS_PER_BIT clocks, with a valid/ready word handshake.
module serial_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    serial_d, ready_d, busy_d, done_d;
  logic                    accept, baud_end, last_bit;

  assign accept   = tx_valid && tx_ready;
  assign baud_end = (baud_q == BAUD_LAST);
  assign last_bit = (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)              state_d = START;
      START:   if (baud_end)            state_d = DATA;
      DATA:    if (baud_end && last_bit) state_d = STOP;
      STOP:    if (baud_end)            state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Counters and shift register; the word is only captured in IDLE, so
  // tx_data changes during a frame never reach the line.
  always_comb begin
    shreg_d = shreg_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    if (state_q == IDLE) begin
      baud_d = '0;
      idx_d  = '0;
      if (accept) shreg_d = tx_data;
    end else begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    if (state_q == DATA && baud_end) begin
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + 1'b1;
    end
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    serial_d = 1'b1;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = (state_q == STOP);
      end
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_d[0];
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      tx_serial <= serial_d;
      tx_ready  <= ready_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: frame-level reference model checked every cycle on
// two configurations (8 bits / 4 clks, 1 bit / 2 clks) plus directed literals.
module tb_serial_tx_framer;

  localparam int FA = (8 + 2) * 4;
  localparam int FB = (1 + 2) * 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_serial, a_busy, a_done;
  logic [0:0] b_data;
  logic       b_valid, b_ready, b_serial, b_busy, b_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_serial(a_serial), .tx_busy(a_busy), .tx_done(a_done)
  );

  serial_tx_framer #(.DATA_WIDTH(1), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_serial(b_serial), .tx_busy(b_busy), .tx_done(b_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h, required %0h", nm, $time, act, req);
  endtask

  // Expected {serial, ready, busy, done}, k clocks after the accepting edge.
  function automatic logic [3:0] exp_out(input bit active, input int k,
                                         input logic [31:0] word, input int dw, input int n);
    int b;
    if (!active)             return 4'b1100;
    if (k == (dw + 2) * n)   return 4'b1101;
    b = k / n;
    if (b == 0)              return 4'b0010;
    if (b <= dw)             return {word[b-1], 3'b010};
    return 4'b1010;
  endfunction

  bit          ma_act = 0, mb_act = 0, ma_rdy, mb_rdy;
  int          ma_k = 0, mb_k = 0;
  logic [31:0] ma_word = '0, mb_word = '0;

  always @(posedge clk) begin
    ma_rdy = !ma_act || (ma_k == FA);
    mb_rdy = !mb_act || (mb_k == FB);
    if (rst) ma_act = 0;
    else if (ma_rdy && a_valid) begin ma_act = 1; ma_k = 0; ma_word = 32'(a_data); end
    else if (ma_act) begin ma_k++; if (ma_k > FA) ma_act = 0; end
    if (rst) mb_act = 0;
    else if (mb_rdy && b_valid) begin mb_act = 1; mb_k = 0; mb_word = 32'(b_data); end
    else if (mb_act) begin mb_k++; if (mb_k > FB) mb_act = 0; end
    #1;
    chk("model_A", 32'({a_serial, a_ready, a_busy, a_done}), 32'(exp_out(ma_act, ma_k, ma_word, 8, 4)));
    chk("model_B", 32'({b_serial, b_ready, b_busy, b_done}), 32'(exp_out(mb_act, mb_k, mb_word, 1, 2)));
  end

  task automatic send_a(input logic [7:0] d);
    @(negedge clk); a_data = d; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
  endtask

  task automatic send_b(input logic d);
    @(negedge clk); b_data = d; b_valid = 1'b1;
    @(negedge clk); b_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc, input string nm);
    int c = 0;
    while (a_done !== 1'b1 && c < maxc) begin @(negedge clk); c++; end
    chk(nm, 32'(a_done), 32'd1);
  endtask

  task automatic wait_done_b(input int maxc, input string nm);
    int c = 0;
    while (b_done !== 1'b1 && c < maxc) begin @(negedge clk); c++; end
    chk(nm, 32'(b_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq_a5;
    logic [7:0] w3c;
    logic [5:0] seq_b;
    int busy_cnt, done_cnt, rdy_cnt, bad, c;
    seq_a5 = 10'b1101001010;
    w3c    = 8'h3C;
    seq_b  = 6'b111100;
    rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_serial", 32'(a_serial), 32'd1);
    chk("reset_ready",  32'(a_ready),  32'd1);
    chk("reset_busy",   32'(a_busy),   32'd0);
    chk("reset_done",   32'(a_done),   32'd0);
    rst = 1'b0;

    // Idle with no traffic.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({a_serial, a_ready, a_busy, a_done} !== 4'b1100) bad++;
      if ({b_serial, b_ready, b_busy, b_done} !== 4'b1100) bad++;
    end
    chk("idle_100", 32'(bad), 32'd0);

    // 0xA5: line levels, busy length, done timing.
    send_a(8'hA5);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < FA; i++) begin
      if (i % 4 == 0) chk($sformatf("a5_bit%0d", i / 4), 32'(a_serial), 32'(seq_a5[i/4]));
      busy_cnt += int'(a_busy);
      done_cnt += int'(a_done);
      @(negedge clk);
    end
    chk("a5_done_at_40", 32'(a_done),  32'd1);
    chk("a5_ready_with_done", 32'(a_ready), 32'd1);
    chk("a5_busy_cycles", 32'(busy_cnt), 32'd40);
    chk("a5_no_early_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    chk("a5_done_one_cycle", 32'(a_done), 32'd0);

    // Back-to-back 0x00 then 0xFF with valid held high.
    @(negedge clk); a_data = 8'h00; a_valid = 1'b1;
    @(negedge clk); a_data = 8'hFF;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("b2b_zero%0d", j), 32'(a_serial), 32'd0);
      repeat (4) @(negedge clk);
    end
    wait_done_a(10, "b2b_done1");
    chk("b2b_gap_idle_high", 32'(a_serial), 32'd1);
    @(negedge clk);
    chk("b2b_frame2_start", 32'({a_serial, a_busy}), 32'b01);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("b2b_one%0d", j), 32'(a_serial), 32'd1);
      repeat (4) @(negedge clk);
    end
    wait_done_a(10, "b2b_done2");

    // 0x3C with upstream noise while busy.
    send_a(8'h3C);
    rdy_cnt = 0;
    for (int i = 0; i < FA; i++) begin
      rdy_cnt += int'(a_ready);
      if (i >= 4 && i < 36 && i % 4 == 0)
        chk($sformatf("3c_bit%0d", i / 4 - 1), 32'(a_serial), 32'(w3c[i/4-1]));
      if (i == 10) a_data = 8'hFF;
      if (i >= 5 && i <= 30) a_valid = i[0];
      if (i == 31) a_valid = 1'b0;
      @(negedge clk);
    end
    chk("3c_ready_low_in_frame", 32'(rdy_cnt), 32'd0);
    chk("3c_done", 32'(a_done), 32'd1);
    bad = 0;
    repeat (10) begin @(negedge clk); bad += int'(a_busy); end
    chk("3c_no_second_frame", 32'(bad), 32'd0);

    // 0x81 aborted by reset at cycle 17, then resent.
    send_a(8'h81);
    repeat (4) @(negedge clk);
    chk("81_bit0", 32'(a_serial), 32'd1);
    repeat (4) @(negedge clk);
    chk("81_bit1", 32'(a_serial), 32'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'({a_serial, a_ready, a_busy, a_done}), 32'b1100);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (45) begin @(negedge clk); bad += int'(a_done); end
    chk("rst_no_done_pulse", 32'(bad), 32'd0);
    send_a(8'h81);
    c = 0;
    while (a_done !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    chk("81_resent_len", 32'(c), 32'd40);

    // Minimum configuration: one data bit, two clocks per bit.
    send_b(1'b1);
    for (int i = 0; i < FB; i++) begin
      chk($sformatf("w1_level%0d", i), 32'(b_serial), 32'(seq_b[i]));
      @(negedge clk);
    end
    chk("w1_done_at_6", 32'({b_done, b_ready}), 32'b11);
    @(negedge clk);
    send_b(1'b0);
    wait_done_b(10, "w1_second_done");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
